// File: rtl/ex_mem_dual.sv
// Dual-lane EX/MEM pipeline register with stall, flush and overflow-trap squash.
// Lane 0 is the older instruction; a trap kills its own lane and every younger lane.
module ex_mem_dual #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid0,
  input  logic [XLEN-1:0] ex_pc0,
  input  logic [XLEN-1:0] ex_result0,
  input  logic            ex_ovf0,
  input  logic            ex_ovf_en0,
  input  logic [XLEN-1:0] ex_store_data0,
  input  logic [RW-1:0]   ex_rd0,
  input  logic            ex_regwrite0,
  input  logic            ex_memread0,
  input  logic            ex_memwrite0,
  input  logic            ex_valid1,
  input  logic [XLEN-1:0] ex_pc1,
  input  logic [XLEN-1:0] ex_result1,
  input  logic            ex_ovf1,
  input  logic            ex_ovf_en1,
  input  logic [XLEN-1:0] ex_store_data1,
  input  logic [RW-1:0]   ex_rd1,
  input  logic            ex_regwrite1,
  input  logic            ex_memread1,
  input  logic            ex_memwrite1,
  output logic            mem_valid0,
  output logic [XLEN-1:0] mem_pc0,
  output logic [XLEN-1:0] mem_result0,
  output logic [XLEN-1:0] mem_store_data0,
  output logic [RW-1:0]   mem_rd0,
  output logic            mem_regwrite0,
  output logic            mem_memread0,
  output logic            mem_memwrite0,
  output logic            mem_valid1,
  output logic [XLEN-1:0] mem_pc1,
  output logic [XLEN-1:0] mem_result1,
  output logic [XLEN-1:0] mem_store_data1,
  output logic [RW-1:0]   mem_rd1,
  output logic            mem_regwrite1,
  output logic            mem_memread1,
  output logic            mem_memwrite1,
  output logic            exc_req,
  output logic            exc_lane,
  output logic [XLEN-1:0] exc_pc,
  input  logic            exc_ack
);

  logic [1:0]            trap_c, kill_c, pass_c;
  logic [1:0]            valid_q, valid_d, regwrite_q, regwrite_d;
  logic [1:0]            memread_q, memread_d, memwrite_q, memwrite_d;
  logic [1:0][XLEN-1:0]  pc_q, pc_d, result_q, result_d, sdata_q, sdata_d;
  logic [1:0][RW-1:0]    rd_q, rd_d;
  logic                  exc_req_q, exc_req_d, exc_lane_q, exc_lane_d;
  logic [XLEN-1:0]       exc_pc_q, exc_pc_d;

  // Next-state: flush bubbles, stall holds, otherwise capture with trap squash.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    pc_d       = pc_q;
    result_d   = result_q;
    sdata_d    = sdata_q;
    rd_d       = rd_q;
    exc_req_d  = exc_req_q;
    exc_lane_d = exc_lane_q;
    exc_pc_d   = exc_pc_q;

    trap_c[0] = ex_valid0 & ex_ovf_en0 & ex_ovf0;
    trap_c[1] = ex_valid1 & ex_ovf_en1 & ex_ovf1;
    kill_c[0] = trap_c[0];
    kill_c[1] = trap_c[0] | trap_c[1];
    pass_c[0] = ex_valid0 & ~kill_c[0] & ~exc_req_q;
    pass_c[1] = ex_valid1 & ~kill_c[1] & ~exc_req_q;

    if (flush) begin
      valid_d    = '0;
      regwrite_d = '0;
      memread_d  = '0;
      memwrite_d = '0;
      pc_d       = '0;
      result_d   = '0;
      sdata_d    = '0;
      rd_d       = '0;
    end else if (!stall) begin
      valid_d    = pass_c;
      regwrite_d = {ex_regwrite1, ex_regwrite0} & pass_c;
      memread_d  = {ex_memread1, ex_memread0} & pass_c;
      memwrite_d = {ex_memwrite1, ex_memwrite0} & pass_c;
      pc_d       = {ex_pc1, ex_pc0};
      result_d   = {ex_result1, ex_result0};
      sdata_d    = {ex_store_data1, ex_store_data0};
      rd_d       = {ex_rd1, ex_rd0};
    end

    // Ack and set are mutually exclusive because set requires no pending request.
    if (exc_req_q) begin
      if (exc_ack) exc_req_d = 1'b0;
    end else if (!stall && !flush && (|trap_c)) begin
      exc_req_d  = 1'b1;
      exc_lane_d = ~trap_c[0];
      exc_pc_d   = trap_c[0] ? ex_pc0 : ex_pc1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      memread_q  <= '0;
      memwrite_q <= '0;
      pc_q       <= '0;
      result_q   <= '0;
      sdata_q    <= '0;
      rd_q       <= '0;
      exc_req_q  <= 1'b0;
      exc_lane_q <= 1'b0;
      exc_pc_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      pc_q       <= pc_d;
      result_q   <= result_d;
      sdata_q    <= sdata_d;
      rd_q       <= rd_d;
      exc_req_q  <= exc_req_d;
      exc_lane_q <= exc_lane_d;
      exc_pc_q   <= exc_pc_d;
    end
  end

  assign mem_valid0      = valid_q[0];
  assign mem_pc0         = pc_q[0];
  assign mem_result0     = result_q[0];
  assign mem_store_data0 = sdata_q[0];
  assign mem_rd0         = rd_q[0];
  assign mem_regwrite0   = regwrite_q[0];
  assign mem_memread0    = memread_q[0];
  assign mem_memwrite0   = memwrite_q[0];
  assign mem_valid1      = valid_q[1];
  assign mem_pc1         = pc_q[1];
  assign mem_result1     = result_q[1];
  assign mem_store_data1 = sdata_q[1];
  assign mem_rd1         = rd_q[1];
  assign mem_regwrite1   = regwrite_q[1];
  assign mem_memread1    = memread_q[1];
  assign mem_memwrite1   = memwrite_q[1];
  assign exc_req         = exc_req_q;
  assign exc_lane        = exc_lane_q;
  assign exc_pc          = exc_pc_q;

endmodule

// File: tb/tb_ex_mem_dual.sv
// Scoreboard bench for ex_mem_dual: a lane-scan reference model predicts each edge,
// a negedge monitor compares every output against the queued prediction.
module tb_ex_mem_dual;

  typedef struct packed {
    logic        v, en, ovf, rw, mr, mw;
    logic [31:0] pc, res, sd;
    logic [4:0]  rd;
  } lane_in_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc, res, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } lane_out_t;

  typedef struct packed {
    lane_out_t   o1, o0;
    logic        req, lane;
    logic [31:0] epc;
  } exp_t;

  logic clk, rst, stall, flush, exc_ack;
  lane_in_t li [2];

  logic        mem_valid0, mem_regwrite0, mem_memread0, mem_memwrite0;
  logic        mem_valid1, mem_regwrite1, mem_memread1, mem_memwrite1;
  logic [31:0] mem_pc0, mem_result0, mem_store_data0;
  logic [31:0] mem_pc1, mem_result1, mem_store_data1;
  logic [4:0]  mem_rd0, mem_rd1;
  logic        exc_req, exc_lane;
  logic [31:0] exc_pc;

  int   total = 0;
  int   bad   = 0;
  exp_t scb[$];
  exp_t mdl;

  ex_mem_dual #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid0(li[0].v), .ex_pc0(li[0].pc), .ex_result0(li[0].res), .ex_ovf0(li[0].ovf),
    .ex_ovf_en0(li[0].en), .ex_store_data0(li[0].sd), .ex_rd0(li[0].rd),
    .ex_regwrite0(li[0].rw), .ex_memread0(li[0].mr), .ex_memwrite0(li[0].mw),
    .ex_valid1(li[1].v), .ex_pc1(li[1].pc), .ex_result1(li[1].res), .ex_ovf1(li[1].ovf),
    .ex_ovf_en1(li[1].en), .ex_store_data1(li[1].sd), .ex_rd1(li[1].rd),
    .ex_regwrite1(li[1].rw), .ex_memread1(li[1].mr), .ex_memwrite1(li[1].mw),
    .mem_valid0(mem_valid0), .mem_pc0(mem_pc0), .mem_result0(mem_result0),
    .mem_store_data0(mem_store_data0), .mem_rd0(mem_rd0), .mem_regwrite0(mem_regwrite0),
    .mem_memread0(mem_memread0), .mem_memwrite0(mem_memwrite0),
    .mem_valid1(mem_valid1), .mem_pc1(mem_pc1), .mem_result1(mem_result1),
    .mem_store_data1(mem_store_data1), .mem_rd1(mem_rd1), .mem_regwrite1(mem_regwrite1),
    .mem_memread1(mem_memread1), .mem_memwrite1(mem_memwrite1),
    .exc_req(exc_req), .exc_lane(exc_lane), .exc_pc(exc_pc), .exc_ack(exc_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk lanes oldest first; the first trap claims the exception and
  // squashes itself and everything younger; a pending exception squashes all.
  function automatic exp_t model_step(input exp_t m);
    exp_t      n;
    lane_out_t o [2];
    logic      squash, rec;
    n = m;
    o[0] = m.o0;
    o[1] = m.o1;
    rec = 1'b0;
    if (!rst) return '0;
    if (flush) begin
      o[0] = '0;
      o[1] = '0;
    end else if (!stall) begin
      squash = m.req;
      for (int i = 0; i < 2; i++) begin
        if (!squash && li[i].v && li[i].en && li[i].ovf) begin
          rec = 1'b1;
          n.lane = (i == 1);
          n.epc = li[i].pc;
          squash = 1'b1;
        end
        o[i].v   = li[i].v & ~squash;
        o[i].rw  = li[i].rw & o[i].v;
        o[i].mr  = li[i].mr & o[i].v;
        o[i].mw  = li[i].mw & o[i].v;
        o[i].pc  = li[i].pc;
        o[i].res = li[i].res;
        o[i].sd  = li[i].sd;
        o[i].rd  = li[i].rd;
      end
    end
    n.req = m.req ? ~exc_ack : rec;
    n.o0 = o[0];
    n.o1 = o[1];
    return n;
  endfunction

  // Predict the coming edge, take it, hand the prediction to the monitor.
  task automatic cyc();
    exp_t e;
    e = model_step(mdl);
    @(posedge clk);
    mdl = e;
    scb.push_back(e);
    #1;
  endtask

  function automatic lane_in_t rand_lane();
    lane_in_t l;
    l.v   = 1'($urandom_range(0, 3) != 0);
    l.en  = 1'($urandom_range(0, 1));
    l.ovf = 1'($urandom_range(0, 5) == 0);
    l.rw  = 1'($urandom_range(0, 1));
    l.mr  = 1'($urandom_range(0, 1));
    l.mw  = 1'($urandom_range(0, 1));
    l.pc  = $urandom;
    l.res = $urandom;
    l.sd  = $urandom;
    l.rd  = 5'($urandom);
    return l;
  endfunction

  function automatic lane_in_t mk(input logic v, input logic trap, input logic [31:0] pc,
                                  input logic [31:0] res, input logic rw, input logic mw);
    lane_in_t l;
    l = '0;
    l.v = v; l.en = trap; l.ovf = trap; l.pc = pc; l.res = res;
    l.rw = rw; l.mw = mw; l.rd = 5'd3;
    return l;
  endfunction

  // Monitor: compare every output once per cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        chk("valid0", mem_valid0, e.o0.v);
        chk("pc0", mem_pc0, e.o0.pc);
        chk("result0", mem_result0, e.o0.res);
        chk("sdata0", mem_store_data0, e.o0.sd);
        chk("rd0", mem_rd0, e.o0.rd);
        chk("ctl0", {mem_regwrite0, mem_memread0, mem_memwrite0}, {e.o0.rw, e.o0.mr, e.o0.mw});
        chk("valid1", mem_valid1, e.o1.v);
        chk("pc1", mem_pc1, e.o1.pc);
        chk("result1", mem_result1, e.o1.res);
        chk("sdata1", mem_store_data1, e.o1.sd);
        chk("rd1", mem_rd1, e.o1.rd);
        chk("ctl1", {mem_regwrite1, mem_memread1, mem_memwrite1}, {e.o1.rw, e.o1.mr, e.o1.mw});
        chk("exc_req", exc_req, e.req);
        chk("exc_lane", exc_lane, e.lane);
        chk("exc_pc", exc_pc, e.epc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    mdl = '0;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; exc_ack = 1'b0;
    li[0] = '0; li[1] = '0;
    cyc(); cyc();
    chk("rst_valid0", mem_valid0, 1'b0);
    chk("rst_exc_req", exc_req, 1'b0);
    rst = 1'b1;

    // Plain lane-0 add, lane 1 idle.
    li[0] = mk(1'b1, 1'b0, 32'h10, 32'h5, 1'b1, 1'b0);
    li[1] = '0;
    cyc();
    chk("t1_valid0", mem_valid0, 1'b1);
    chk("t1_result0", mem_result0, 32'h5);
    chk("t1_rd0", mem_rd0, 5'd3);
    chk("t1_valid1", mem_valid1, 1'b0);
    chk("t1_exc_req", exc_req, 1'b0);

    // Lane-0 trap kills younger store.
    li[0] = mk(1'b1, 1'b1, 32'h100, 32'h7, 1'b1, 1'b0);
    li[1] = mk(1'b1, 1'b0, 32'h104, 32'h8, 1'b0, 1'b1);
    cyc();
    chk("t2_valid0", mem_valid0, 1'b0);
    chk("t2_valid1", mem_valid1, 1'b0);
    chk("t2_memwrite1", mem_memwrite1, 1'b0);
    chk("t2_exc_req", exc_req, 1'b1);
    chk("t2_exc_lane", exc_lane, 1'b0);
    chk("t2_exc_pc", exc_pc, 32'h100);
    li[0] = '0; li[1] = '0; exc_ack = 1'b1;
    cyc();
    exc_ack = 1'b0;
    chk("t2_ack_clr", exc_req, 1'b0);
    chk("t2_pc_held", exc_pc, 32'h100);

    // Lane-1 trap: lane 0 survives, later pairs squashed through the ack cycle.
    li[0] = mk(1'b1, 1'b0, 32'h200, 32'h11, 1'b1, 1'b0);
    li[1] = mk(1'b1, 1'b1, 32'h204, 32'h12, 1'b1, 1'b0);
    cyc();
    chk("t3_valid0", mem_valid0, 1'b1);
    chk("t3_valid1", mem_valid1, 1'b0);
    chk("t3_exc_lane", exc_lane, 1'b1);
    chk("t3_exc_pc", exc_pc, 32'h204);
    li[0] = mk(1'b1, 1'b0, 32'h208, 32'h21, 1'b1, 1'b0);
    li[1] = mk(1'b1, 1'b0, 32'h20c, 32'h22, 1'b1, 1'b0);
    cyc();
    chk("t3_squash0", mem_valid0, 1'b0);
    exc_ack = 1'b1;
    cyc();
    exc_ack = 1'b0;
    chk("t3_ack_squash", mem_valid0, 1'b0);
    chk("t3_ack_clr", exc_req, 1'b0);
    cyc();
    chk("t3_pass0", mem_valid0, 1'b1);
    chk("t3_pass1", mem_valid1, 1'b1);
    chk("t3_res1", mem_result1, 32'h22);

    // Stall three cycles with changing inputs and a trap on lane 0.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      li[0] = mk(1'b1, 1'b1, 32'h300 + 32'(k), 32'h40 + 32'(k), 1'b1, 1'b0);
      li[1] = mk(1'b1, 1'b0, 32'h380 + 32'(k), 32'h50 + 32'(k), 1'b1, 1'b1);
      cyc();
    end
    chk("t4_frozen", mem_result0, 32'h21);
    chk("t4_no_exc", exc_req, 1'b0);

    // Stall and flush together with a lane-0 trap.
    flush = 1'b1;
    cyc();
    stall = 1'b0; flush = 1'b0;
    chk("t5_valid0", mem_valid0, 1'b0);
    chk("t5_valid1", mem_valid1, 1'b0);
    chk("t5_exc_req", exc_req, 1'b0);

    // Async reset while an exception is pending.
    cyc();
    chk("t6_req_set", exc_req, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_req", exc_req, 1'b0);
    chk("t6_async_pc", exc_pc, 32'h0);
    chk("t6_async_valid1", mem_valid1, 1'b0);
    mdl = '0;
    cyc();
    rst = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      li[0]   = rand_lane();
      li[1]   = rand_lane();
      stall   = 1'($urandom_range(0, 5) == 0);
      flush   = 1'($urandom_range(0, 9) == 0);
      exc_ack = 1'($urandom_range(0, 3) == 0);
      cyc();
    end
    stall = 1'b0; flush = 1'b0; exc_ack = 1'b0;
    li[0] = '0; li[1] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("scb_drained", 64'(scb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
